// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a four-floor elevator: latches call pulses, selects the next
// target floor, holds it through travel and dwell, and flags trips that never arrive.
module elevator_call_scheduler #(
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [3:0] i_calls,
    input  logic [1:0] i_current_floor,
    output logic [1:0] o_target_floor,
    output logic [3:0] o_pending,
    output logic       o_dir,
    output logic       o_busy,
    output logic       o_arrived,
    output logic       o_fault
);

    localparam int TRAVEL_W = $clog2(TIMEOUT_CYCLES);
    localparam int DWELL_W  = $clog2(DWELL_CYCLES + 1);

    localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_TRAVEL = 2'd2;
    localparam logic [1:0] ST_DWELL  = 2'd3;

    // Floors at or above the given floor.
    function automatic logic [3:0] ge_mask(input logic [1:0] floor);
        logic [3:0] m;
        case (floor)
            2'd0:    m = 4'b1111;
            2'd1:    m = 4'b1110;
            2'd2:    m = 4'b1100;
            2'd3:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Floors at or below the given floor.
    function automatic logic [3:0] le_mask(input logic [1:0] floor);
        logic [3:0] m;
        case (floor)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            2'd3:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] lowest_floor(input logic [3:0] set);
        logic [1:0] f;
        if (set[0])      f = 2'd0;
        else if (set[1]) f = 2'd1;
        else if (set[2]) f = 2'd2;
        else             f = 2'd3;
        return f;
    endfunction

    function automatic logic [1:0] highest_floor(input logic [3:0] set);
        logic [1:0] f;
        if (set[3])      f = 2'd3;
        else if (set[2]) f = 2'd2;
        else if (set[1]) f = 2'd1;
        else             f = 2'd0;
        return f;
    endfunction

    function automatic logic [3:0] floor_onehot(input logic [1:0] floor);
        logic [3:0] m;
        case (floor)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0010;
            2'd2:    m = 4'b0100;
            2'd3:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [1:0]          state_r;
    logic [3:0]          pending_r;
    logic [1:0]          target_r;
    logic                dir_r;
    logic                busy_r;
    logic                arrived_r;
    logic                fault_r;
    logic [TRAVEL_W-1:0] travel_cnt_r;
    logic [DWELL_W-1:0]  dwell_cnt_r;

    logic [3:0]          up_set_s;
    logic [3:0]          down_set_s;
    logic [1:0]          sel_target_s;
    logic                sel_dir_s;

    logic [1:0]          state_s;
    logic [3:0]          pending_s;
    logic [3:0]          clear_mask_s;
    logic [1:0]          target_s;
    logic                dir_s;
    logic                arrived_s;
    logic                fault_s;
    logic [TRAVEL_W-1:0] travel_cnt_s;
    logic [DWELL_W-1:0]  dwell_cnt_s;

    // SCAN choice: keep sweeping while calls remain ahead, otherwise reverse.
    always_comb begin
        up_set_s     = pending_r & ge_mask(i_current_floor);
        down_set_s   = pending_r & le_mask(i_current_floor);
        sel_target_s = target_r;
        sel_dir_s    = dir_r;
        if (!dir_r) begin
            if (up_set_s != 4'b0000) begin
                sel_target_s = lowest_floor(up_set_s);
                sel_dir_s    = 1'b0;
            end else begin
                sel_target_s = highest_floor(pending_r & ~ge_mask(i_current_floor));
                sel_dir_s    = 1'b1;
            end
        end else begin
            if (down_set_s != 4'b0000) begin
                sel_target_s = highest_floor(down_set_s);
                sel_dir_s    = 1'b1;
            end else begin
                sel_target_s = lowest_floor(pending_r & ~le_mask(i_current_floor));
                sel_dir_s    = 1'b0;
            end
        end
    end

    // Next-state, counters and retire mask for the call being served.
    always_comb begin
        state_s      = state_r;
        clear_mask_s = 4'b0000;
        target_s     = target_r;
        dir_s        = dir_r;
        arrived_s    = 1'b0;
        fault_s      = fault_r;
        travel_cnt_s = travel_cnt_r;
        dwell_cnt_s  = dwell_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 4'b0000) begin
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                target_s     = sel_target_s;
                dir_s        = sel_dir_s;
                travel_cnt_s = {TRAVEL_W{1'b0}};
                state_s      = ST_TRAVEL;
            end
            ST_TRAVEL: begin
                if (i_current_floor == target_r) begin
                    state_s     = ST_DWELL;
                    arrived_s   = 1'b1;
                    dwell_cnt_s = {DWELL_W{1'b0}};
                end else if (travel_cnt_r == TRAVEL_LAST) begin
                    state_s      = ST_IDLE;
                    fault_s      = 1'b1;
                    clear_mask_s = floor_onehot(target_r);
                    travel_cnt_s = {TRAVEL_W{1'b0}};
                end else begin
                    travel_cnt_s = travel_cnt_r + {{(TRAVEL_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DWELL: begin
                if (dwell_cnt_r == DWELL_LAST) begin
                    state_s      = ST_IDLE;
                    clear_mask_s = floor_onehot(target_r);
                    dwell_cnt_s  = {DWELL_W{1'b0}};
                end else begin
                    dwell_cnt_s = dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Clear wins over a same-edge call for the retiring floor.
        pending_s = (pending_r | i_calls) & ~clear_mask_s;
    end

    // State and output registers; reset discards any calls sampled on the same edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            pending_r    <= 4'b0000;
            target_r     <= 2'd0;
            dir_r        <= 1'b0;
            busy_r       <= 1'b0;
            arrived_r    <= 1'b0;
            fault_r      <= 1'b0;
            travel_cnt_r <= {TRAVEL_W{1'b0}};
            dwell_cnt_r  <= {DWELL_W{1'b0}};
        end else begin
            state_r      <= state_s;
            pending_r    <= pending_s;
            target_r     <= target_s;
            dir_r        <= dir_s;
            busy_r       <= (state_s != ST_IDLE);
            arrived_r    <= arrived_s;
            fault_r      <= fault_s;
            travel_cnt_r <= travel_cnt_s;
            dwell_cnt_r  <= dwell_cnt_s;
        end
    end

    assign o_target_floor = target_r;
    assign o_pending      = pending_r;
    assign o_dir          = dir_r;
    assign o_busy         = busy_r;
    assign o_arrived      = arrived_r;
    assign o_fault        = fault_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Randomized scoreboard bench for elevator_call_scheduler with a moving-elevator model
// and a SCAN reference that predicts the service order of each call batch.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] calls;
    logic [1:0] elev_floor = 2'd0;
    logic [1:0] o_target_floor;
    logic [3:0] o_pending;
    logic       o_dir;
    logic       o_busy;
    logic       o_arrived;
    logic       o_fault;

    int tests = 0;
    int fails = 0;
    bit model_dir = 1'b0;
    bit freeze = 1'b0;
    int move_cnt = 0;

    typedef struct packed {
        logic [1:0] floor;
        logic       dir;
    } exp_t;
    exp_t exp_q[$];

    elevator_call_scheduler #(.DWELL_CYCLES(4), .TIMEOUT_CYCLES(80)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_calls(calls),
        .i_current_floor(elev_floor),
        .o_target_floor(o_target_floor),
        .o_pending(o_pending),
        .o_dir(o_dir),
        .o_busy(o_busy),
        .o_arrived(o_arrived),
        .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Elevator: one floor per 20 cycles toward the requested floor unless frozen.
    always @(negedge clk) begin
        if (!freeze && elev_floor != o_target_floor) begin
            if (move_cnt == 19) begin
                move_cnt = 0;
                elev_floor = (elev_floor < o_target_floor) ? elev_floor + 2'd1 : elev_floor - 2'd1;
            end else begin
                move_cnt++;
            end
        end else begin
            move_cnt = 0;
        end
    end

    // Monitor: every arrival pulse is matched against the next predicted service.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (o_arrived) begin
            check("arrival_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("arrive_target", o_target_floor, e.floor);
                check("arrive_dir", o_dir, e.dir);
                check("arrive_floor", elev_floor, e.floor);
            end
        end
    end

    // SCAN rule from the current position and sweep direction.
    task automatic next_target(input logic [3:0] set, input int pos, input bit dir,
                               output int t, output bit nd);
        t = -1;
        nd = dir;
        if (!dir) begin
            for (int f = pos; f <= 3; f++) if (set[f] && t < 0) t = f;
            if (t < 0) begin
                for (int f = pos - 1; f >= 0; f--) if (set[f] && t < 0) t = f;
                nd = 1'b1;
            end
        end else begin
            for (int f = pos; f >= 0; f--) if (set[f] && t < 0) t = f;
            if (t < 0) begin
                for (int f = pos + 1; f <= 3; f++) if (set[f] && t < 0) t = f;
                nd = 1'b0;
            end
        end
    endtask

    task automatic push_exp(input int t, input bit d);
        exp_t e;
        e.floor = 2'(t);
        e.dir = d;
        exp_q.push_back(e);
    endtask

    task automatic push_plan(input logic [3:0] set_in, input int pos_in);
        logic [3:0] s;
        int p;
        int t;
        bit nd;
        s = set_in;
        p = pos_in;
        while (s != 4'b0000) begin
            next_target(s, p, model_dir, t, nd);
            push_exp(t, nd);
            s[t] = 1'b0;
            p = t;
            model_dir = nd;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!(o_busy == 1'b0 && o_pending == 4'b0000 && elev_floor == o_target_floor) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_within_budget", int'(n < 3000), 1);
    endtask

    task automatic run_scenario(input logic [3:0] set, input logic [3:0] extra);
        int pos;
        int t0;
        bit d0;
        logic [3:0] rest;
        logic [3:0] oh;
        wait_ready();
        pos = int'(elev_floor);
        next_target(set, pos, model_dir, t0, d0);
        model_dir = d0;
        push_exp(t0, d0);
        oh = 4'b0001 << t0;
        calls = set;
        @(negedge clk);
        calls = 4'b0000;
        check("pending_latched", o_pending, set);
        repeat (2) @(posedge clk);
        #1;
        check("select_target", o_target_floor, t0);
        check("select_dir", o_dir, d0);
        check("busy_in_travel", o_busy, 1);
        rest = set & ~oh;
        if (t0 == pos) begin
            @(posedge clk);
            #1;
            check("parked_arrival_latency", o_arrived, 1);
        end else if (extra != 4'b0000) begin
            @(negedge clk);
            calls = extra;
            @(negedge clk);
            calls = 4'b0000;
            @(posedge clk);
            #1;
            check("target_frozen", o_target_floor, t0);
            check("extra_latched", o_pending & extra, extra);
            rest = (set | extra) & ~oh;
        end
        push_plan(rest, t0);
        wait_ready();
        check("queue_drained", exp_q.size(), 0);
        check("idle_not_busy", o_busy, 0);
    endtask

    task automatic run_timeout();
        int pos;
        int tgt;
        int t;
        bit nd;
        logic [3:0] oh;
        wait_ready();
        pos = int'(elev_floor);
        tgt = (pos + 2) % 4;
        oh = 4'b0001 << tgt;
        freeze = 1'b1;
        next_target(oh, pos, model_dir, t, nd);
        model_dir = nd;
        calls = oh;
        @(negedge clk);
        calls = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("timeout_target", o_target_floor, tgt);
        check("timeout_dir", o_dir, nd);
        repeat (79) @(posedge clk);
        #1;
        check("fault_before_limit", o_fault, 0);
        check("busy_before_limit", o_busy, 1);
        @(posedge clk);
        #1;
        check("fault_at_limit", o_fault, 1);
        check("idle_after_timeout", o_busy, 0);
        check("pending_cleared_timeout", o_pending[tgt], 0);
        repeat (5) @(posedge clk);
        #1;
        check("fault_sticky", o_fault, 1);
        @(negedge clk);
        freeze = 1'b0;
        wait_ready();
        check("fault_sticky_after_move", o_fault, 1);
    endtask

    task automatic run_reset_mid_travel();
        int pos;
        wait_ready();
        pos = int'(elev_floor);
        calls = 4'b0001 << ((pos + 2) % 4);
        @(negedge clk);
        calls = 4'b0000;
        repeat (10) @(negedge clk);
        check("busy_before_reset", o_busy, 1);
        rst = 1'b1;
        calls = 4'b1111;
        @(posedge clk);
        #1;
        check("rst_target", o_target_floor, 0);
        check("rst_pending", o_pending, 0);
        check("rst_dir", o_dir, 0);
        check("rst_busy", o_busy, 0);
        check("rst_arrived", o_arrived, 0);
        check("rst_fault", o_fault, 0);
        @(negedge clk);
        rst = 1'b0;
        calls = 4'b0000;
        exp_q.delete();
        model_dir = 1'b0;
        @(posedge clk);
        #1;
        check("rst_calls_discarded", o_pending, 0);
        check("rst_stays_idle", o_busy, 0);
    endtask

    initial begin
        logic [3:0] rset;
        logic [3:0] rextra;
        rst = 1'b1;
        calls = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_target", o_target_floor, 0);
        check("reset_pending", o_pending, 0);
        check("reset_dir", o_dir, 0);
        check("reset_arrived", o_arrived, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_busy", o_busy, 0);
            check("idle_target", o_target_floor, 0);
            check("idle_pending", o_pending, 0);
            check("idle_fault", o_fault, 0);
        end

        run_scenario(4'b1000, 4'b0000);
        run_scenario(4'b0001, 4'b0000);
        run_scenario(4'b0010, 4'b0000);
        run_scenario(4'b1001, 4'b0000);
        run_scenario(4'b0001, 4'b0000);
        run_scenario(4'b0100, 4'b0010);
        run_scenario(4'b1111, 4'b0000);

        for (int i = 0; i < 24; i++) begin
            rset = 4'($urandom_range(1, 15));
            rextra = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            run_scenario(rset, rextra);
        end

        run_timeout();
        run_reset_mid_travel();

        for (int i = 0; i < 4; i++) begin
            rset = 4'($urandom_range(1, 15));
            rextra = 4'($urandom_range(0, 15));
            run_scenario(rset, rextra);
        end
        check("fault_clear_after_reset", o_fault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", tests);
        $fatal(1);
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Front end that drives the elevator's floor-request input (`i_buttons`) and watches its current-floor output (`o_current_floor`).
- Latches asynchronous call-button pulses for floors 0-3 into a pending set and picks the next target with a SCAN policy (keep direction while calls remain ahead).
- Holds each target stable until the elevator reports arrival, dwells, then retires the request.
- Instantiated between the button panel and the elevator core.

Parameters:
- DWELL_CYCLES, 4: cycles spent at a served floor before the next selection; must be ≥1.
- TIMEOUT_CYCLES, 80: maximum TRAVEL cycles before the request is abandoned and a fault is flagged; must be ≥2.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_calls  input  4  call-button pulses, one bit per floor; any width, OR-accumulated.
- i_current_floor  input  2  floor reported by the elevator.
- o_target_floor  output  2  requested floor; connects to the elevator's `i_buttons`.
- o_pending  output  4  latched, unserved calls.
- o_dir  output  1  sweep direction: 0 = up, 1 = down.
- o_busy  output  1  high whenever state ≠ IDLE.
- o_arrived  output  1  one-cycle pulse on arrival at the target.
- o_fault  output  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (sampled on a clock edge, overrides everything, including mid-TRAVEL):
  - o_pending=0, o_target_floor=0, o_dir=0, o_busy=0, o_arrived=0, o_fault=0.
  - State=IDLE; travel and dwell counters = 0.
- Call latch: every edge, pending_next = (pending | i_calls) & ~clear_mask.
  - clear_mask is nonzero only on the DWELL-exit edge or the timeout edge. It is one-hot at target.
  - A call for the floor being retired on the same edge is absorbed (clear wins).
  - Calls for the target floor during TRAVEL or DWELL are also absorbed, since the doors serve them.
- States IDLE, SELECT, TRAVEL, DWELL:
  - IDLE: if pending ≠ 0, go to SELECT on the next edge; otherwise stay. o_target_floor holds its last value so the elevator stays parked.
  - SELECT, one cycle; o_target_floor and o_dir are registered on exit to TRAVEL.
    - Up (dir=0): target = lowest pending floor ≥ i_current_floor. If none, target = highest pending floor < current and dir←1.
    - Down (dir=1): target = highest pending floor ≤ current. If none, target = lowest pending floor > current and dir←0.
  - TRAVEL: the travel counter increments each cycle; o_target_floor is frozen, so new calls never retarget mid-trip.
    - If i_current_floor == o_target_floor: go to DWELL and pulse o_arrived for exactly one cycle, the first DWELL cycle.
    - Else if the counter reaches TIMEOUT_CYCLES-1: set o_fault, clear the target's pending bit, go to IDLE.
  - DWELL: stay exactly DWELL_CYCLES cycles, then clear the target's pending bit and go to IDLE.
- Latency:
  - A call sampled at edge N appears in o_pending after edge N.
  - From an idle start: SELECT after edge N+1; new o_target_floor and TRAVEL after edge N+2.
  - A call for the floor the elevator is already parked on reaches DWELL at edge N+3.
- Boundaries:
  - Simultaneous calls on all floors are all latched.
  - The pending set never loses a call except by service or timeout.
  - o_dir changes only in SELECT.
  - No underflow or overflow on floor arithmetic; all comparisons are 2-bit unsigned.

Test Plan:
- Reset, then hold i_calls=0 for 10 cycles → o_busy=0, o_target_floor=0, o_pending=0, o_fault=0 throughout.
- Elevator parked at floor 0; pulse i_calls=4'b1000 → o_target_floor=3 two cycles after the sample edge. With the elevator model moving one floor per 20 cycles: o_arrived pulses once, DWELL lasts 4 cycles, then o_pending=0 and o_busy=0.
- Elevator at floor 1 with dir=0; pulse i_calls=4'b1001 together → service order 3 then 0 (dir flips to 1 at the second SELECT). o_arrived pulses twice; final o_pending=0.
- Elevator travelling 0→2; pulse a call for floor 1 during TRAVEL → o_target_floor stays 2 until arrival. Floor 1 is served next; o_pending bit 1 remains set until its DWELL exit.
- Elevator model frozen at floor 0 with a call to floor 2 → after 80 TRAVEL cycles o_fault=1, o_pending[2]=0, state returns to IDLE. o_fault persists until i_reset.
- Assert i_reset during TRAVEL → all outputs return to their reset values on the next edge; calls presented in the same cycle as reset are discarded.
